bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 27 ++
 rtl/bus_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/bus_arbiter_if.sv
// Bus arbiter signal bundle: CPU/DMA handshake inputs and arbitration outputs.
// master = the arbiter, slave = the CPU/DMA/video side driving the requests.
interface bus_arbiter_if #(
    parameter int CNT_W = 8
);
    logic             cpu_ce;
    logic             cpu_we;
    logic             dma_req;
    logic             dma_last;
    logic             wsync_req;
    logic             line_start;
    logic             halt_b;
    logic             rdy;
    logic             dma_grant;
    logic             bus_sel;
    logic [CNT_W-1:0] dma_cycles;

    modport master (
        input  cpu_ce, cpu_we, dma_req, dma_last, wsync_req, line_start,
        output halt_b, rdy, dma_grant, bus_sel, dma_cycles
    );

    modport slave (
        output cpu_ce, cpu_we, dma_req, dma_last, wsync_req, line_start,
        input  halt_b, rdy, dma_grant, bus_sel, dma_cycles
    );
endinterface

// File: rtl/bus_arbiter.sv
// CPU / video-DMA bus arbiter: halts the CPU only after a read cycle, inserts
// turnaround gaps around each DMA grant, counts grant length and handles WSYNC stalls.
module bus_arbiter #(
    parameter int CNT_W       = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.master bus
);
    typedef enum logic [2:0] {
        S_CPU, S_HALT_PEND, S_TURN, S_DMA, S_RELEASE
    } state_e;

    localparam logic [1:0] TURN_LAST = 2'(TURN_CYCLES - 1);

    state_e           state_q, state_d;
    logic [1:0]       turn_cnt_q, turn_cnt_d;
    logic             halt_b_q, halt_b_d;
    logic             rdy_q, rdy_d;
    logic             dma_grant_q, dma_grant_d;
    logic             bus_sel_q, bus_sel_d;
    logic [CNT_W-1:0] dma_cycles_q, dma_cycles_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_CPU;
            turn_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            turn_cnt_q <= turn_cnt_d;
        end
    end

    // HALT_PEND waits for a read cycle to finish so a CPU write is never cut short.
    always_comb begin
        state_d    = state_q;
        turn_cnt_d = turn_cnt_q;
        unique case (state_q)
            S_CPU: begin
                if (bus.dma_req) state_d = S_HALT_PEND;
            end
            S_HALT_PEND: begin
                if (!bus.dma_req) begin
                    state_d = S_CPU;
                end else if (bus.cpu_ce && !bus.cpu_we) begin
                    state_d    = S_TURN;
                    turn_cnt_d = '0;
                end
            end
            S_TURN: begin
                if (turn_cnt_q == TURN_LAST) state_d = S_DMA;
                else                         turn_cnt_d = turn_cnt_q + 2'd1;
            end
            S_DMA: begin
                if (bus.dma_last || !bus.dma_req) begin
                    state_d    = S_RELEASE;
                    turn_cnt_d = '0;
                end
            end
            S_RELEASE: begin
                if (turn_cnt_q == TURN_LAST) state_d = S_CPU;
                else                         turn_cnt_d = turn_cnt_q + 2'd1;
            end
            default: state_d = S_CPU;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        halt_b_d     = 1'b1;
        dma_grant_d  = 1'b0;
        bus_sel_d    = 1'b0;
        dma_cycles_d = dma_cycles_q;
        rdy_d        = rdy_q;
        unique case (state_d)
            S_TURN, S_RELEASE: halt_b_d = 1'b0;
            S_DMA: begin
                halt_b_d    = 1'b0;
                dma_grant_d = 1'b1;
                bus_sel_d   = 1'b1;
            end
            default: ;
        endcase
        if (state_q == S_DMA)
            dma_cycles_d = sat_inc(dma_cycles_q);
        else if (state_q == S_HALT_PEND && state_d == S_TURN)
            dma_cycles_d = '0;
        if (bus.wsync_req)       rdy_d = 1'b0;
        else if (bus.line_start) rdy_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            halt_b_q     <= 1'b1;
            rdy_q        <= 1'b1;
            dma_grant_q  <= 1'b0;
            bus_sel_q    <= 1'b0;
            dma_cycles_q <= '0;
        end else begin
            halt_b_q     <= halt_b_d;
            rdy_q        <= rdy_d;
            dma_grant_q  <= dma_grant_d;
            bus_sel_q    <= bus_sel_d;
            dma_cycles_q <= dma_cycles_d;
        end
    end

    assign bus.halt_b     = halt_b_q;
    assign bus.rdy        = rdy_q;
    assign bus.dma_grant  = dma_grant_q;
    assign bus.bus_sel    = bus_sel_q;
    assign bus.dma_cycles = dma_cycles_q;
endmodule
